// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame scheduler.
// Define CONV_PAD_EN to run a padded (same-size) grid and export per-window border masks.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } state_e;

`ifdef CONV_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // Bit positions inside eng_pad_mask = {top, bottom, left, right}.
    localparam int PAD_TOP   = 3;
    localparam int PAD_BOT   = 2;
    localparam int PAD_LEFT  = 1;
    localparam int PAD_RIGHT = 0;

    function automatic int out_dim(input int img, input int k);
        return PAD_EN ? img : (img - k + 1);
    endfunction

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: col runs first, wraps at OUT_W-1 and bumps row.
// Latency: clr/adv take effect on the next edge; last is combinational from the count.
// Backpressure: none, it moves only when adv is asserted.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int OUT_W   = 3,
    parameter int OUT_H   = 3,
`ifdef CONV_PAD_EN
    parameter int HALF    = 1,
`endif
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
`ifdef CONV_PAD_EN
    output logic [3:0]         pad_mask,
`endif
    output logic               last
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(OUT_H - 1);

    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + COORD_W'(1);
            end else begin
                col_d = col_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

`ifdef CONV_PAD_EN
    logic [3:0] mask_q, mask_d;

    // Mask is derived from the next position so it lands in the same edge as row/col.
    always_comb begin
        mask_d = mask_q;
        if (clr || adv) begin
            mask_d[PAD_TOP]   = int'(row_d) < HALF;
            mask_d[PAD_BOT]   = int'(row_d) > (OUT_H - 1 - HALF);
            mask_d[PAD_LEFT]  = int'(col_d) < HALF;
            mask_d[PAD_RIGHT] = int'(col_d) > (OUT_W - 1 - HALF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else        mask_q <= mask_d;
    end

    assign pad_mask = mask_q;
`endif

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv_scheduler.sv
// Walks one conv engine over the output grid in raster order, one result per start/done pair.
// Latency: start->eng_start 1, eng_done->out_valid 1, handshake->next eng_start 1 (3 cycles/pixel min).
// Backpressure: result held on out_valid until out_ready; no new window is issued meanwhile.
// CONV_PAD_EN selects the padded grid and adds eng_pad_mask.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int K       = 3,
    parameter int COORD_W = 8,
    parameter int ACC_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               eng_start,
    output logic [COORD_W-1:0] eng_row,
    output logic [COORD_W-1:0] eng_col,
    input  logic               eng_done,
    input  logic [ACC_W-1:0]   eng_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_err
`ifdef CONV_PAD_EN
    ,
    output logic [3:0]         eng_pad_mask
`endif
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int WD_W  = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               eng_start_q, eng_start_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               timeout_err_q, timeout_err_d;
    logic               pos_clr, pos_adv, pos_last;

    conv_pos_counter #(
        .OUT_W   (OUT_W),
        .OUT_H   (OUT_H),
`ifdef CONV_PAD_EN
        .HALF    ((K - 1) / 2),
`endif
        .COORD_W (COORD_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pos_clr),
        .adv      (pos_adv),
        .row      (eng_row),
        .col      (eng_col),
`ifdef CONV_PAD_EN
        .pad_mask (eng_pad_mask),
`endif
        .last     (pos_last)
    );

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        eng_start_d   = 1'b0;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        pos_clr       = 1'b0;
        pos_adv       = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pos_clr       = 1'b1;
                    wd_d          = '0;
                    timeout_err_d = 1'b0;
                    eng_start_d   = 1'b1;
                    state_d       = ISSUE;
                end
                ISSUE: begin
                    wd_d    = '0;
                    state_d = WAIT;
                end
                // A done arriving on the watchdog's final cycle still counts.
                WAIT: if (eng_done) begin
                    out_data_d  = eng_result;
                    out_valid_d = 1'b1;
                    out_last_d  = pos_last;
                    state_d     = EMIT;
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                EMIT: if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        pos_adv     = 1'b1;
                        eng_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wd_q          <= '0;
            eng_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            eng_start_q   <= eng_start_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign eng_start   = eng_start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler on a 5x5 image, K=3, watchdog of 8 cycles.
module tb_conv_scheduler;

`ifdef CONV_PAD_EN
    localparam int OUT_W = 5;
    localparam int OUT_H = 5;
`else
    localparam int OUT_W = 3;
    localparam int OUT_H = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        eng_start;
    logic [7:0]  eng_row;
    logic [7:0]  eng_col;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
`ifdef CONV_PAD_EN
    logic [3:0]  eng_pad_mask;
`endif

    int total = 0;
    int bad   = 0;
    int idx;

    conv_scheduler #(
        .IMG_W(5), .IMG_H(5), .K(3), .COORD_W(8), .ACC_W(16), .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .eng_start   (eng_start),
        .eng_row     (eng_row),
        .eng_col     (eng_col),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .frame_done  (frame_done),
`ifdef CONV_PAD_EN
        .eng_pad_mask(eng_pad_mask),
`endif
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pad_exp(input int r, input int c);
        int m = 0;
        if (r == 0)         m += 8;
        if (r == OUT_H - 1) m += 4;
        if (c == 0)         m += 2;
        if (c == OUT_W - 1) m += 1;
        return m;
    endfunction

    // Called on the negedge where eng_start should be high; returns on the
    // negedge where the captured result is first visible on out_valid.
    task automatic do_pixel(input int r, input int c, input bit lst, input logic [15:0] res);
        chk("eng_start", 32'(eng_start), 1);
        chk("eng_row", 32'(eng_row), r);
        chk("eng_col", 32'(eng_col), c);
`ifdef CONV_PAD_EN
        chk("pad_mask", 32'(eng_pad_mask), pad_exp(r, c));
`endif
        @(negedge clk);
        chk("start_pulse", 32'(eng_start), 0);
        @(negedge clk);
        eng_done   = 1'b1;
        eng_result = res;
        @(negedge clk);
        eng_done = 1'b0;
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(res));
        chk("out_last", 32'(out_last), 32'(lst));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        eng_done = 1'b0; eng_result = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_row", 32'(eng_row), 0);
        chk("rst_col", 32'(eng_col), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Full frame with a 10-cycle stall at (1,1) and a stray start during it.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 1);
        for (int r = 0; r < OUT_H; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                idx = r * OUT_W + c;
                if (r == 1 && c == 1) out_ready = 1'b0;
                do_pixel(r, c, idx == OUT_W * OUT_H - 1, 16'(16'hA000 + idx));
                if (r == 1 && c == 1) begin
                    for (int i = 0; i < 10; i++) begin
                        start = (i == 2);
                        @(negedge clk);
                        chk("hold_valid", 32'(out_valid), 1);
                        chk("hold_data", 32'(out_data), 32'(16'hA000 + idx));
                        chk("hold_no_start", 32'(eng_start), 0);
                    end
                    start = 1'b0;
                    out_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk("frame_done", 32'(frame_done), 1);
        chk("done_valid", 32'(out_valid), 0);
        chk("done_busy", 32'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("frame_done_pulse", 32'(frame_done), 0);
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("start_in_done_ignored", 32'(eng_start), 0);
        chk("idle_busy2", 32'(busy), 0);

        // Engine never answers: watchdog expires after 8 WAIT cycles.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("done_in_idle_ignored", 32'(out_valid), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_eng_start", 32'(eng_start), 1);
        repeat (8) @(negedge clk);
        chk("to_not_yet", 32'(timeout_err), 0);
        chk("to_busy_wait", 32'(busy), 1);
        @(negedge clk);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_no_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        chk("to_sticky", 32'(timeout_err), 1);

        // Restart clears the error; abort while waiting at (2,0).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_cleared", 32'(timeout_err), 0);
        for (int p = 0; p < 2 * OUT_W; p++) begin
            do_pixel(p / OUT_W, p % OUT_W, 1'b0, 16'(16'hB000 + p));
            @(negedge clk);
        end
        chk("ab_eng_start", 32'(eng_start), 1);
        chk("ab_row", 32'(eng_row), 2);
        chk("ab_col", 32'(eng_col), 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(out_valid), 0);
        chk("ab_frame_done", 32'(frame_done), 0);
        eng_done = 1'b1;
        eng_result = 16'hDEAD;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        chk("ab_late_done_valid", 32'(out_valid), 0);
        chk("ab_late_done_busy", 32'(busy), 0);

        // Done on the watchdog's final cycle wins over the timeout.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_eng_start", 32'(eng_start), 1);
        chk("rs_row", 32'(eng_row), 0);
        chk("rs_col", 32'(eng_col), 0);
        repeat (8) @(negedge clk);
        eng_done = 1'b1;
        eng_result = 16'h5A5A;
        @(negedge clk);
        eng_done = 1'b0;
        chk("dw_valid", 32'(out_valid), 1);
        chk("dw_data", 32'(out_data), 32'h5A5A);
        chk("dw_no_timeout", 32'(timeout_err), 0);
        @(negedge clk);
        chk("dw_next_start", 32'(eng_start), 1);
        chk("dw_next_col", 32'(eng_col), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("dw_abort_busy", 32'(busy), 0);

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_eng_start", 32'(eng_start), 0);
        @(negedge clk);
        chk("sa_busy2", 32'(busy), 0);

        // Asynchronous reset in the middle of EMIT.
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        eng_done = 1'b1;
        eng_result = 16'hBEEF;
        @(negedge clk);
        eng_done = 1'b0;
        chk("re_valid_before", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("re_valid", 32'(out_valid), 0);
        chk("re_data", 32'(out_data), 0);
        chk("re_busy", 32'(busy), 0);
        chk("re_last", 32'(out_last), 0);
        chk("re_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
